// File: rtl/matrix_seq_ctrl_pkg.sv
// Shared types and constants for the matrix multiply sequencer.
package matrix_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MUL,
    S_WR,
    S_DONE
  } state_t;

  localparam int MAT_COLS    = 4;
  localparam int IDX_W       = 2;   // row/word index width, covers up to 4 rows and MAT_COLS words
  localparam int ROW_STRIDE  = 16;
  localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/matrix_seq_addr_gen.sv
// Combinational A-row read address and C-word write address from latched bases.
module matrix_seq_addr_gen
  import matrix_seq_ctrl_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0]    base_a,
  input  logic [AW-1:0]    base_c,
  input  logic [IDX_W-1:0] row,
  input  logic [IDX_W-1:0] word,
  output logic [AW-1:0]    rd_addr,
  output logic [AW-1:0]    wr_addr
);

  // Plain modular adds: unaligned base bits [1:0] pass straight through.
  assign rd_addr = base_a + AW'(WORD_STRIDE) * AW'(row);
  assign wr_addr = base_c + AW'(ROW_STRIDE) * AW'(row) + AW'(WORD_STRIDE) * AW'(word);

endmodule

// File: rtl/matrix_seq_ctrl.sv
// EX-stage matrix multiply sequencer: per row of A fetch a line, run the
// datapath for one cycle, write four product words to C; stalls the pipe meanwhile.
module matrix_seq_ctrl
  import matrix_seq_ctrl_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_c,
  output logic          stall_o,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          line_req,
  output logic          line_we,
  output logic [AW-1:0] line_addr,
  output logic [31:0]   line_wdata,
  input  logic [31:0]   line_rdata,
  input  logic          line_valid,
  output logic [31:0]   row_line_o,
  output logic          mul_en,
  input  logic [127:0]  mul_result_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                     state;
  logic [AW-1:0]              base_a_q, base_c_q, rd_addr, wr_addr;
  logic [IDX_W-1:0]           row, word;
  logic [TW-1:0]              tcnt;
  logic [MAT_COLS-1:0][31:0]  result;
  logic                       xfer, tmo;

  matrix_seq_addr_gen #(.AW(AW)) u_addr (
    .base_a  (base_a_q),
    .base_c  (base_c_q),
    .row     (row),
    .word    (word),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr)
  );

  assign xfer       = line_req & line_valid;
  assign tmo        = line_req & ~line_valid & (tcnt == TW'(TIMEOUT - 1));
  assign stall_o    = busy | (start & (state == S_IDLE));
  assign line_addr  = line_we ? wr_addr : rd_addr;
  assign line_wdata = result[word];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      base_a_q   <= '0;
      base_c_q   <= '0;
      row        <= '0;
      word       <= '0;
      tcnt       <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      line_req   <= 1'b0;
      line_we    <= 1'b0;
      row_line_o <= '0;
      mul_en     <= 1'b0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      mul_en <= 1'b0;
      if (abort) begin
        // A transfer accepted in this cycle is dropped along with the sequence.
        state    <= S_IDLE;
        busy     <= 1'b0;
        line_req <= 1'b0;
        line_we  <= 1'b0;
        tcnt     <= '0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            base_a_q <= base_a;
            base_c_q <= base_c;
            row      <= '0;
            word     <= '0;
            tcnt     <= '0;
            busy     <= 1'b1;
            line_req <= 1'b1;
            line_we  <= 1'b0;
            state    <= S_RD;
          end
          S_RD: begin
            if (xfer) begin
              row_line_o <= line_rdata;
              line_req   <= 1'b0;
              mul_en     <= 1'b1;
              tcnt       <= '0;
              state      <= S_MUL;
            end else if (tmo) begin
              line_req <= 1'b0;
              done     <= 1'b1;
              err      <= 1'b1;
              state    <= S_DONE;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_MUL: begin
            result   <= mul_result_i;
            word     <= '0;
            tcnt     <= '0;
            line_req <= 1'b1;
            line_we  <= 1'b1;
            state    <= S_WR;
          end
          S_WR: begin
            if (xfer) begin
              tcnt <= '0;
              if (word == IDX_W'(MAT_COLS - 1)) begin
                word    <= '0;
                line_we <= 1'b0;
                if (row == IDX_W'(ROWS - 1)) begin
                  line_req <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_DONE;
                end else begin
                  // line_req stays high straight into the next row's read
                  row   <= row + 1'b1;
                  state <= S_RD;
                end
              end else begin
                word <= word + 1'b1;
              end
            end else if (tmo) begin
              line_req <= 1'b0;
              line_we  <= 1'b0;
              done     <= 1'b1;
              err      <= 1'b1;
              state    <= S_DONE;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy     <= 1'b0;
            line_req <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Bench for matrix_seq_ctrl: transaction-queue reference model checked every
// cycle, plus directed scenarios with hand-computed latencies and addresses.
module tb_matrix_seq_ctrl;

  localparam int ROWS = 4;
  localparam int TMO  = 8;
  localparam int AW   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0;
  logic [AW-1:0] base_a = '0, base_c = '0;
  logic          stall_o, busy, done, err, line_req, line_we, mul_en;
  logic [AW-1:0] line_addr;
  logic [31:0]   line_wdata, row_line_o;
  logic [31:0]   line_rdata = '0;
  logic          line_valid = 1'b0;
  logic [127:0]  mul_result_i;

  always #5 clk = ~clk;

  matrix_seq_ctrl #(.ROWS(ROWS), .TIMEOUT(TMO), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_a(base_a), .base_c(base_c), .stall_o(stall_o), .busy(busy),
    .done(done), .err(err), .line_req(line_req), .line_we(line_we),
    .line_addr(line_addr), .line_wdata(line_wdata), .line_rdata(line_rdata),
    .line_valid(line_valid), .row_line_o(row_line_o), .mul_en(mul_en),
    .mul_result_i(mul_result_i)
  );

  int checks = 0, errors = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Product word k of the datapath stand-in.
  function automatic logic [31:0] f(input logic [31:0] d, input int k);
    return d * 32'(k + 1) + 32'(k);
  endfunction

  logic [127:0] junk = '0;
  always @(negedge clk) junk = {$urandom, $urandom, $urandom, $urandom};
  always_comb begin
    mul_result_i = '0;
    for (int k = 0; k < 4; k++)
      mul_result_i[32*k +: 32] = mul_en ? f(row_line_o, k) : junk[32*k +: 32];
  end

  // Memory responder: dmode 0 zero-wait, 1 fixed 3 waits, 2 random 0..3 waits
  int          dmode = 0;
  bit          hang_en = 1'b0;
  logic [31:0] hang_addr = '0;
  int          rcnt = -1;
  always @(posedge clk) begin
    #2;
    if (rst || !line_req) begin
      rcnt       = -1;
      line_valid = (dmode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      line_rdata = $urandom;
    end else begin
      if (rcnt < 0) rcnt = (dmode == 0) ? 0 : (dmode == 1) ? 3 : int'($urandom_range(0, 3));
      line_rdata = $urandom;
      if (hang_en && !line_we && line_addr == hang_addr) line_valid = 1'b0;
      else if (rcnt == 0) begin line_valid = 1'b1; rcnt = -1; end
      else begin line_valid = 1'b0; rcnt--; end
    end
  end

  // Reference model: queue of transfers still owed by the current sequence.
  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } op_t;
  op_t         ops[$];
  op_t         op;
  bit          m_busy, exp_mul, exp_done, exp_err, exp_req;
  int          m_row, m_wait, cyc, stall_cnt;
  logic [31:0] m_rd, m_ba, m_bc;
  int          acc_cyc[$], done_cyc[$];
  bit          done_err[$];
  logic [31:0] rd_log[$], wr_log[$];

  initial begin : model
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; exp_mul = 0; exp_done = 0; exp_err = 0; ops.delete();
      end else begin
        cyc++;
        if (stall_o) stall_cnt++;
        if (done) begin done_cyc.push_back(cyc); done_err.push_back(err); end
        exp_req = m_busy && !exp_mul && !exp_done && ops.size() > 0;
        check("busy", busy, m_busy);
        check("stall_o", stall_o, m_busy | start);
        check("done", done, exp_done);
        check("err", err, exp_err);
        check("mul_en", mul_en, exp_mul);
        if (exp_mul) check("row_line_o", row_line_o, m_rd);
        check("line_req", line_req, exp_req);
        if (exp_req) begin
          check("line_we", line_we, ops[0].we);
          check("line_addr", line_addr, ops[0].addr);
          if (ops[0].we) check("line_wdata", line_wdata, ops[0].data);
        end
        if (abort) begin
          m_busy = 0; exp_mul = 0; exp_done = 0; exp_err = 0; ops.delete();
        end else if (!m_busy) begin
          if (start) begin
            m_busy = 1; m_row = 0; m_ba = base_a; m_bc = base_c; m_wait = 0;
            ops.push_back('{we:1'b0, addr:base_a, data:32'h0});
            acc_cyc.push_back(cyc);
          end
        end else if (exp_done) begin
          m_busy = 0; exp_done = 0; exp_err = 0;
        end else if (exp_mul) begin
          exp_mul = 0; m_wait = 0;
          for (int k = 0; k < 4; k++)
            ops.push_back('{we:1'b1, addr:m_bc + 32'(16*m_row) + 32'(4*k), data:f(m_rd, k)});
        end else if (line_valid) begin
          op = ops.pop_front();
          m_wait = 0;
          if (!op.we) begin
            m_rd = line_rdata; rd_log.push_back(op.addr); exp_mul = 1;
          end else begin
            wr_log.push_back(op.addr);
            if (ops.size() == 0) begin
              if (m_row == ROWS - 1) exp_done = 1;
              else begin
                m_row++;
                ops.push_back('{we:1'b0, addr:m_ba + 32'(4*m_row), data:32'h0});
              end
            end
          end
        end else begin
          m_wait++;
          if (m_wait == TMO) begin exp_done = 1; exp_err = 1; ops.delete(); end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("reached_idle", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] c);
    base_a = a; base_c = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  int r0, w0, a0, d0, s0;
  task automatic snap();
    r0 = rd_log.size(); w0 = wr_log.size(); a0 = acc_cyc.size();
    d0 = done_cyc.size(); s0 = stall_cnt;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin : main
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall_o, 0);    check("rst_busy", busy, 0);
    check("rst_done", done, 0);        check("rst_err", err, 0);
    check("rst_req", line_req, 0);     check("rst_we", line_we, 0);
    check("rst_addr", line_addr, 0);   check("rst_wdata", line_wdata, 0);
    check("rst_line", row_line_o, 0);  check("rst_mul", mul_en, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // zero-wait full sequence
    snap();
    pulse_start(32'h100, 32'h200);
    wait_idle(100);
    check("t1_reads", rd_log.size() - r0, 4);
    for (int i = 0; i < 4; i++) check("t1_rd_addr", rd_log[r0+i], 32'h100 + 32'(4*i));
    check("t1_writes", wr_log.size() - w0, 16);
    check("t1_wr_first", wr_log[w0], 32'h200);
    check("t1_wr_last", wr_log[w0+15], 32'h23C);
    check("t1_latency", done_cyc[d0] - acc_cyc[a0], 25);
    check("t1_stall_cycles", stall_cnt - s0, 26);
    check("t1_no_err", done_err[d0], 0);

    // three wait states on every transfer
    dmode = 1;
    snap();
    pulse_start(32'h1000, 32'h2000);
    wait_idle(300);
    check("t2_latency", done_cyc[d0] - acc_cyc[a0], 4*21 + 1);
    check("t2_writes", wr_log.size() - w0, 16);

    // row-1 read never answered
    dmode = 0; hang_en = 1'b1; hang_addr = 32'h304;
    snap();
    pulse_start(32'h300, 32'h400);
    wait_idle(100);
    hang_en = 1'b0;
    check("t3_latency", done_cyc[d0] - acc_cyc[a0], 15);
    check("t3_err", done_err[d0], 1);
    check("t3_writes", wr_log.size() - w0, 4);
    check("t3_reads", rd_log.size() - r0, 1);

    // abort during WR word 2 of row 0
    snap();
    pulse_start(32'h600, 32'h700);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_req", line_req, 0);
    check("t4_done", done, 0);
    repeat (5) @(posedge clk);
    #1;
    check("t4_writes", wr_log.size() - w0, 2);
    check("t4_no_done", done_cyc.size() - d0, 0);

    // async reset in MUL, then restart
    pulse_start(32'h80, 32'h900);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t5_busy", busy, 0);      check("t5_req", line_req, 0);
    check("t5_mul", mul_en, 0);     check("t5_line", row_line_o, 0);
    check("t5_stall", stall_o, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    snap();
    pulse_start(32'h40, 32'hA00);
    wait_idle(100);
    check("t5_first_rd", rd_log[r0], 32'h40);
    check("t5_done_cnt", done_cyc.size() - d0, 1);

    // start held through a whole sequence and into its done cycle
    snap();
    base_a = 32'h500; base_c = 32'hB00; start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (acc_cyc.size() - a0 >= 2) break;
    end
    start = 1'b0;
    check("t6_accepts", acc_cyc.size() - a0, 2);
    if (acc_cyc.size() - a0 >= 2 && done_cyc.size() - d0 >= 1) begin
      check("t6_gap", acc_cyc[a0+1] - acc_cyc[a0], 26);
      check("t6_after_done", acc_cyc[a0+1] - done_cyc[d0], 1);
    end
    wait_idle(100);
    check("t6_done_cnt", done_cyc.size() - d0, 2);

    // randomized sequences with noise, aborts, stray starts, wrapping bases
    for (int n = 0; n < 40; n++) begin
      dmode   = int'($urandom_range(0, 2));
      hang_en = ($urandom_range(0, 9) == 0);
      base_a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF5 : $urandom;
      base_c  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE3 : $urandom;
      hang_addr = base_a + 32'(4 * $urandom_range(0, 3));
      pulse_start(base_a, base_c);
      for (int c = 0; c < 400 && busy; c++) begin
        start = ($urandom_range(0, 3) == 0);
        abort = ($urandom_range(0, 99) == 0);
        @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0;
      wait_idle(200);
    end
    hang_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
